uart_byte_fifo: RTL and testbench
=================================

Name: uart_byte_fifo

Overview:
- Byte buffer between the UART receiver and the UART transmitter in the loopback path.
- Captures each byte the receiver completes and stores it in a circular FIFO.
- Replays the bytes to the transmitter at one frame per byte, paced internally. The transmitter has no busy output, so the FIFO cannot rely on it.
- Decouples bursty RX from TX, and is the insertion point for later byte processing.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).
- CLK_HZ, 25000000, clk frequency in Hz.
- BAUD, 9600, line baud rate.
- TX_PULSE, 4, number of cycles tx_int is held high per byte.
- GAP_CYCLES, (CLK_HZ/BAUD)*11, idle wait after each tx_int falling edge. This is one 10-bit frame plus 1 bit of margin; integer division. Default value is 28644.

Ports:
- clk  in  1  system clock, 25 MHz domain.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the receiver; valid at the falling edge of rx_int.
- rx_int  in  1  receiver busy flag; its falling edge means a byte is complete.
- tx_data  out  8  byte to the transmitter.
- tx_int  out  1  start strobe to the transmitter; its falling edge launches transmission of tx_data.
- fifo_count  out  ADDR_W+1  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear for overflow.

Behaviour:
- Reset (asynchronous, rst_n low):
  - tx_data=8'h00, tx_int=0, fifo_count=0, overflow=0.
  - Read and write pointers = 0, FSM = IDLE, gap counter = 0.
  - rx_int edge registers = 0.
  - Reset mid-transfer discards all FIFO contents and any in-flight pulse; no partial pulse is emitted after release.
- Write side:
  - rx_int is registered once (rx_int_d). A write event is rx_int_d=1 and rx_int=0.
  - On a write event with count<DEPTH: mem[wr_ptr]<=rx_data, wr_ptr+1 (wraps modulo DEPTH).
  - On a write event with count==DEPTH: byte is dropped, overflow<=1, pointers unchanged.
- Overflow flag: ovf_clr=1 sets overflow<=0. If ovf_clr and a drop occur in the same cycle, set wins.
- Read FSM states: IDLE, LOAD, PULSE, GAP.
  - IDLE: if count>0, go to LOAD; otherwise stay in IDLE.
  - LOAD (1 cycle): tx_data<=mem[rd_ptr], rd_ptr+1 (wraps), go to PULSE.
  - PULSE: tx_int=1 for exactly TX_PULSE cycles, then tx_int<=0 and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: from a write event into an empty FIFO to tx_int rising is 2 cycles (IDLE->LOAD->PULSE).
- Throughput: one byte per 2+TX_PULSE+GAP_CYCLES cycles.
- tx_data is held stable from LOAD until the next LOAD.
- fifo_count:
  - +1 on an accepted write; -1 on the LOAD pop.
  - Write and pop in the same cycle: count unchanged, both take effect.
  - A full FIFO with a pop in the same cycle as a write event accepts the write (no drop).
- Empty FIFO: FSM stays in IDLE, tx_int stays 0, tx_data keeps its last value.
- Pointer wrap: ADDR_W-bit pointers wrap naturally; full/empty is decided only from fifo_count.

Optional Feature:
- Macro: UART_FIFO_CRLF_EN.
- When defined:
  - After a byte 8'h0D completes GAP, the FSM enters an extra state LF.
  - LF loads tx_data<=8'h0A without popping, then runs PULSE and GAP as normal.
  - fifo_count is unaffected by the inserted byte.
  - A following 8'h0A in the FIFO is still sent, so CR LF input produces CR LF LF.
- When undefined: the LF state is absent and bytes pass through unchanged.

Test Plan:
- Reset, then one write event with rx_data=8'h55 -> tx_int high on cycles 2..5 after the event, tx_data=8'h55. fifo_count goes 1 then 0. Next pulse no earlier than 28644 cycles after the tx_int falling edge.
- Burst of 3 write events (8'h01, 8'h02, 8'h03) 10 cycles apart -> fifo_count peaks at 2. Three pulses in order 01, 02, 03, spaced 2+4+28644 cycles.
- 17 write events with TX held in GAP -> first 16 stored, 17th dropped, overflow=1, fifo_count=16. ovf_clr pulse -> overflow=0.
- Write event coincident with LOAD at count=16 -> byte accepted, count stays 16, overflow stays 0.
- rst_n low during PULSE -> tx_int=0 immediately, fifo_count=0. After release, no tx_int until a new write event.
- With UART_FIFO_CRLF_EN, write 8'h0D -> two pulses, tx_data 8'h0D then 8'h0A. fifo_count 1 then 0 (never negative). Without the macro -> a single 8'h0D pulse.

Source files
------------

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO between UART RX and TX, replayed at one paced frame per byte.
// Optional UART_FIFO_CRLF_EN: each 8'h0D sent is followed by an inserted 8'h0A.
module uart_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int TX_PULSE   = 4,
  parameter int GAP_CYCLES = (CLK_HZ / BAUD) * 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_int,
  output logic [7:0]        tx_data,
  output logic              tx_int,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] FULL       = (ADDR_W + 1)'(DEPTH);
  localparam logic [31:0]     PULSE_LAST = 32'(TX_PULSE - 1);
  localparam logic [31:0]     GAP_LAST   = 32'(GAP_CYCLES - 1);

`ifdef UART_FIFO_CRLF_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    GAP,
    LF
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    GAP
  } state_t;
`endif

  state_t state;
  state_t state_n;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_n;
  logic [31:0]       cnt;
  logic              rx_int_d;
  logic              wr_ev;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ev = rx_int_d & ~rx_int;
  assign pop   = (state == LOAD);
  assign push  = wr_ev & ((fifo_count != FULL) | pop);
  assign drop  = wr_ev & ~push;

  always_comb begin
    count_n = fifo_count;
    if (push && !pop) begin
      count_n = fifo_count + 1'b1;
    end else if (pop && !push) begin
      count_n = fifo_count - 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) state_n = LOAD;
      end
      LOAD: begin
        state_n = PULSE;
      end
      PULSE: begin
        if (cnt == PULSE_LAST) state_n = GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
`ifdef UART_FIFO_CRLF_EN
          state_n = (tx_data == 8'h0D) ? LF : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef UART_FIFO_CRLF_EN
      LF: begin
        state_n = PULSE;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_int_d   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cnt        <= '0;
      tx_data    <= 8'h00;
      tx_int     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_int_d   <= rx_int;
      state      <= state_n;
      fifo_count <= count_n;
      tx_int     <= (state_n == PULSE);
      cnt        <= (state_n != state) ? '0 : cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
`ifdef UART_FIFO_CRLF_EN
      if (state == LF) tx_data <= 8'h0A;
`endif
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb_uart_byte_fifo: scoreboard bench; BAUD raised so one gap is 110 cycles.
// Follows UART_FIFO_CRLF_EN when the design is built with it.
module tb_uart_byte_fifo;

  localparam int GAP = 110;
  localparam int TXP = 4;
  localparam int PER = 2 + TXP + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_int = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_int;
  logic [4:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int peak = 0;
  logic [7:0] exp_q [$];
  int rise_q [$];

  uart_byte_fifo #(
    .DEPTH(16),
    .ADDR_W(4),
    .CLK_HZ(25000000),
    .BAUD(2500000),
    .TX_PULSE(TXP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_int(rx_int),
    .tx_data(tx_data),
    .tx_int(tx_int),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard on every tx_int rise.
  logic tx_prev = 1'b0;
  int rise_cyc = 0;
  int fall_cyc = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_prev  = 1'b0;
      fall_cyc = -1;
    end else begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (tx_int && !tx_prev) begin
        rise_cyc = cyc;
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: tx_data %0h, expected no pulse", tx_data);
        end else begin
          check("tx_data", int'(tx_data), int'(exp_q.pop_front()));
        end
        if (fall_cyc >= 0)
          check("gap_min", int'((cyc - fall_cyc) >= GAP + 1), 1);
      end
      if (!tx_int && tx_prev) begin
        fall_cyc = cyc;
        check("pulse_width", cyc - rise_cyc, TXP);
      end
      tx_prev = tx_int;
    end
  end

  task automatic wr(input logic [7:0] d, output int ev);
    @(posedge clk); #1;
    rx_int  = 1'b1;
    rx_data = d;
    @(posedge clk); #1;
    rx_int = 1'b0;
    ev = cyc + 1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic wait_rise(output int r);
    int n;
    n = 0;
    while (rise_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rise_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rise_timeout: got no pulse, expected one");
      r = -1;
    end else begin
      r = rise_q.pop_front();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, e3, r1, r2, r3, tgt;

    repeat (3) @(negedge clk);
    check("rst_tx_int", int'(tx_int), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_data", int'(tx_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single byte: latency, count trace, hold after replay
    exp_q.push_back(8'h55);
    wr(8'h55, e1);
    at_cycle(e1);
    check("t1_count_one", int'(fifo_count), 1);
    at_cycle(e1 + 2);
    check("t1_count_zero", int'(fifo_count), 0);
    wait_rise(r1);
    check("t1_latency", r1 - e1, 2);
    at_cycle(r1 + TXP + GAP + 10);
    check("t1_idle_tx_int", int'(tx_int), 0);
    check("t1_hold_tx_data", int'(tx_data), 8'h55);

    // Burst of three, 10 cycles apart
    peak = 0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    wr(8'h01, e1);
    repeat (8) @(posedge clk);
    wr(8'h02, e2);
    repeat (8) @(posedge clk);
    wr(8'h03, e3);
    check("t2_spacing", e3 - e1, 20);
    at_cycle(e3 + 1);
    check("t2_peak", peak, 2);
    wait_rise(r1);
    wait_rise(r2);
    wait_rise(r3);
    check("t2_latency", r1 - e1, 2);
    check("t2_period_a", r2 - r1, PER);
    check("t2_period_b", r3 - r2, PER);
    at_cycle(r3 + TXP + GAP + 10);

    // Overflow while TX sits in GAP, then write coincident with LOAD at full
    exp_q.push_back(8'hA0);
    wr(8'hA0, e1);
    wait_rise(r1);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      wr((i < 16) ? 8'(8'h10 + i) : 8'hEE, e2);
    end
    at_cycle(e2);
    check("t3_count_full", int'(fifo_count), 16);
    check("t3_overflow_set", int'(overflow), 1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("t3_overflow_clr", int'(overflow), 0);
    tgt = r1 + TXP + GAP;
    while (cyc < tgt) begin
      @(posedge clk); #1;
    end
    rx_int  = 1'b1;
    rx_data = 8'hC7;
    exp_q.push_back(8'hC7);
    @(posedge clk); #1;
    rx_int = 1'b0;
    e3 = cyc + 1;
    at_cycle(e3);
    check("t4_count_held", int'(fifo_count), 16);
    check("t4_no_overflow", int'(overflow), 0);
    for (int i = 0; i < 17; i++) wait_rise(r2);
    at_cycle(r2 + TXP + GAP + 10);
    check("t4_drained", int'(fifo_count), 0);
    check("t4_scoreboard_empty", exp_q.size(), 0);

    // Reset during PULSE
    exp_q.push_back(8'h66);
    wr(8'h66, e1);
    wr(8'h67, e2);
    wait_rise(r1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_tx_int_cut", int'(tx_int), 0);
    check("t5_count_clear", int'(fifo_count), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rise_q.delete();
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("t5_no_pulse", rise_q.size(), 0);

    // CR handling
    exp_q.push_back(8'h0D);
`ifdef UART_FIFO_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    wr(8'h0D, e1);
    at_cycle(e1);
    check("t6_count_one", int'(fifo_count), 1);
    wait_rise(r1);
    check("t6_latency", r1 - e1, 2);
`ifdef UART_FIFO_CRLF_EN
    wait_rise(r2);
    check("t6_lf_spacing", r2 - r1, TXP + GAP + 1);
    check("t6_count_zero", int'(fifo_count), 0);
    at_cycle(r2 + TXP + GAP + 10);
`else
    at_cycle(r1 + TXP + GAP + 20);
    check("t6_single_pulse", rise_q.size(), 0);
    check("t6_count_zero", int'(fifo_count), 0);
`endif
    check("t6_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
